// File: rtl/glm_dot_scheduler_if.sv
// rtl/glm_dot_scheduler_if.sv - command, operator and status signals of the GLM dot scheduler
//
// slave  : scheduler side (takes commands, drives dot_start/regs, reports status)
// master : environment side (decoder, dot operator, result FIFO occupancy)
//   cmd_*          minibatch command with valid/ready handshake, cmd_abort level
//   dot_start      one-cycle operator start, dot_regs3/dot_regs4 configuration words
//   dot_done       operator completion pulse
//   out_fifo_count dot-result FIFO occupancy
//   busy/done/samples_done  minibatch status
interface glm_dot_scheduler_if #(
    parameter int CNT_W = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [15:0]      cmd_num_samples;
    logic [15:0]      cmd_lines_per_sample;
    logic [15:0]      cmd_model_offset;
    logic [15:0]      cmd_labels_offset;
    logic [15:0]      cmd_labels_stride;
    logic [1:0]       cmd_flags;
    logic             cmd_abort;
    logic             dot_start;
    logic [31:0]      dot_regs3;
    logic [31:0]      dot_regs4;
    logic             dot_done;
    logic [CNT_W-1:0] out_fifo_count;
    logic             busy;
    logic             done;
    logic [15:0]      samples_done;

    modport slave (
        input  cmd_valid, cmd_num_samples, cmd_lines_per_sample, cmd_model_offset,
               cmd_labels_offset, cmd_labels_stride, cmd_flags, cmd_abort,
               dot_done, out_fifo_count,
        output cmd_ready, dot_start, dot_regs3, dot_regs4, busy, done, samples_done
    );

    modport master (
        output cmd_valid, cmd_num_samples, cmd_lines_per_sample, cmd_model_offset,
               cmd_labels_offset, cmd_labels_stride, cmd_flags, cmd_abort,
               dot_done, out_fifo_count,
        input  cmd_ready, dot_start, dot_regs3, dot_regs4, busy, done, samples_done
    );
endinterface

// File: rtl/glm_dot_scheduler.sv
// rtl/glm_dot_scheduler.sv - issues one GLM dot-operator start per minibatch sample
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    glm_dot_scheduler_if.slave: command handshake, operator start/config,
//          operator done, result FIFO occupancy, busy/done/samples_done status
// All outputs are registered.
module glm_dot_scheduler #(
    parameter int OUT_FIFO_DEPTH = 512,
    parameter int CNT_W          = 10,
    parameter int START_GAP      = 2
) (
    input  logic              clk,
    input  logic              reset,
    glm_dot_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_FIFO_DEPTH);
    localparam logic [7:0]       GAP_LAST = 8'(START_GAP - 1);

    state_t      state, state_next;
    logic        cmd_ready_q, dot_start_q, busy_q, done_q, abort_q;
    logic [31:0] regs3_q, regs4_q;
    logic [15:0] samples_done_q, num_q, lines_q, model_q, labels_cur_q, stride_q;
    logic [1:0]  flags_q;
    logic [7:0]  gap_cnt_q;

    logic accept, start, sample_fin, abort_now, credit_ok, sample_last;

    // Only one sample is ever in flight, so a single free slot is enough credit.
    assign credit_ok   = bus.out_fifo_count < DEPTH_C;
    assign abort_now   = abort_q | bus.cmd_abort;
    assign sample_last = (samples_done_q + 16'd1) == num_q;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        start      = 1'b0;
        sample_fin = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    accept     = 1'b1;
                    state_next = (bus.cmd_num_samples == 16'd0) ? S_DONE : S_CREDIT;
                end
            end
            S_CREDIT: begin
                if (abort_now) begin
                    state_next = S_DONE;
                end else if (credit_ok) begin
                    start      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A started sample always runs to completion, abort or not.
                if (bus.dot_done) begin
                    sample_fin = 1'b1;
                    state_next = (sample_last || abort_now) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (abort_now) begin
                    state_next = S_DONE;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_next = S_CREDIT;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cmd_ready_q    <= 1'b0;
            dot_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            abort_q        <= 1'b0;
            regs3_q        <= 32'd0;
            regs4_q        <= 32'd0;
            samples_done_q <= 16'd0;
            num_q          <= 16'd0;
            lines_q        <= 16'd0;
            model_q        <= 16'd0;
            labels_cur_q   <= 16'd0;
            stride_q       <= 16'd0;
            flags_q        <= 2'd0;
            gap_cnt_q      <= 8'd0;
        end else begin
            state       <= state_next;
            // Ready drops for the first IDLE cycle after reset or DONE.
            cmd_ready_q <= (state == S_IDLE) && !accept;
            dot_start_q <= start;
            done_q      <= (state == S_DONE);
            gap_cnt_q   <= (state == S_GAP) ? gap_cnt_q + 8'd1 : 8'd0;

            if (state == S_DONE) begin
                busy_q  <= 1'b0;
                abort_q <= 1'b0;
            end else if (state != S_IDLE && bus.cmd_abort) begin
                abort_q <= 1'b1;
            end

            if (accept) begin
                num_q          <= bus.cmd_num_samples;
                lines_q        <= bus.cmd_lines_per_sample;
                model_q        <= bus.cmd_model_offset;
                labels_cur_q   <= bus.cmd_labels_offset;
                stride_q       <= bus.cmd_labels_stride;
                flags_q        <= bus.cmd_flags;
                samples_done_q <= 16'd0;
                busy_q         <= 1'b1;
                abort_q        <= 1'b0;
            end

            // Config words change only at a start, so they hold until the next one.
            if (start) begin
                regs3_q <= {14'd0, flags_q, lines_q};
                regs4_q <= {labels_cur_q, model_q};
            end

            if (sample_fin) begin
                samples_done_q <= samples_done_q + 16'd1;
                labels_cur_q   <= labels_cur_q + stride_q;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.dot_start    = dot_start_q;
    assign bus.dot_regs3    = regs3_q;
    assign bus.dot_regs4    = regs4_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.samples_done = samples_done_q;
endmodule

// File: tb/tb_glm_dot_scheduler.sv
// tb/tb_glm_dot_scheduler.sv - directed self-checking bench for glm_dot_scheduler
module tb_glm_dot_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    glm_dot_scheduler_if #(.CNT_W(10)) dut_if ();

    glm_dot_scheduler #(
        .OUT_FIFO_DEPTH(512),
        .CNT_W(10),
        .START_GAP(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(dut_if.slave)
    );

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int n_start = 0;
    int n_done = 0;
    int last_done_cyc = -1000;
    int op_cnt = 0;
    int op_lat = 20;
    logic [31:0] log3 [64];
    logic [31:0] log4 [64];
    int gap_log [64];

    // Monitor plus operator model; the operator keeps counting through reset so a
    // late dot_done can be delivered to an idle scheduler.
    always @(negedge clk) begin
        cyc++;
        if (dut_if.dot_start === 1'b1) begin
            if (n_start < 64) begin
                log3[n_start]    = dut_if.dot_regs3;
                log4[n_start]    = dut_if.dot_regs4;
                gap_log[n_start] = cyc - last_done_cyc;
            end
            n_start++;
        end
        if (dut_if.dot_done === 1'b1) last_done_cyc = cyc;
        if (dut_if.done === 1'b1) n_done++;
        dut_if.dot_done = 1'b0;
        if (dut_if.dot_start === 1'b1) begin
            op_cnt = op_lat;
        end else if (op_cnt > 0) begin
            op_cnt--;
            if (op_cnt == 0) dut_if.dot_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input string tag, input logic [15:0] num, input logic [15:0] lines,
                            input logic [15:0] model, input logic [15:0] labels,
                            input logic [15:0] stride, input logic [1:0] flags);
        int k;
        dut_if.cmd_num_samples      = num;
        dut_if.cmd_lines_per_sample = lines;
        dut_if.cmd_model_offset     = model;
        dut_if.cmd_labels_offset    = labels;
        dut_if.cmd_labels_stride    = stride;
        dut_if.cmd_flags            = flags;
        dut_if.cmd_valid            = 1'b1;
        for (k = 0; k < 100 && dut_if.cmd_ready !== 1'b1; k++) tick();
        check({tag, "_ready"}, {31'd0, dut_if.cmd_ready}, 32'd1);
        tick();
        dut_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        for (k = 0; k < limit && dut_if.done !== 1'b1; k++) tick();
        check({tag, "_done_seen"}, {31'd0, dut_if.done}, 32'd1);
    endtask

    task automatic wait_starts(input string tag, input int base, input int n, input int limit);
        int k;
        for (k = 0; k < limit && (n_start - base) < n; k++) tick();
        check({tag, "_starts_seen"}, n_start - base, n);
    endtask

    initial begin
        int b;
        int nd;
        dut_if.cmd_valid            = 1'b0;
        dut_if.cmd_num_samples      = 16'd0;
        dut_if.cmd_lines_per_sample = 16'd0;
        dut_if.cmd_model_offset     = 16'd0;
        dut_if.cmd_labels_offset    = 16'd0;
        dut_if.cmd_labels_stride    = 16'd0;
        dut_if.cmd_flags            = 2'd0;
        dut_if.cmd_abort            = 1'b0;
        dut_if.out_fifo_count       = 10'd0;

        // Reset state
        tick(); tick(); tick();
        check("rst_cmd_ready", {31'd0, dut_if.cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, dut_if.busy}, 32'd0);
        check("rst_done", {31'd0, dut_if.done}, 32'd0);
        check("rst_dot_start", {31'd0, dut_if.dot_start}, 32'd0);
        check("rst_regs3", dut_if.dot_regs3, 32'd0);
        check("rst_regs4", dut_if.dot_regs4, 32'd0);
        check("rst_samples", {16'd0, dut_if.samples_done}, 32'd0);
        reset = 1'b0;
        check("rst_ready_low_after_release", {31'd0, dut_if.cmd_ready}, 32'd0);
        tick();
        check("rst_ready_high", {31'd0, dut_if.cmd_ready}, 32'd1);

        // Three samples, stride 4, label subtraction flag
        b  = n_start;
        nd = n_done;
        send_cmd("t1", 16'd3, 16'd4, 16'h0010, 16'h0100, 16'd4, 2'b10);
        check("t1_busy", {31'd0, dut_if.busy}, 32'd1);
        check("t1_start_not_yet", {31'd0, dut_if.dot_start}, 32'd0);
        tick();
        check("t1_first_start", {31'd0, dut_if.dot_start}, 32'd1);
        wait_done("t1", 500);
        check("t1_busy_clear", {31'd0, dut_if.busy}, 32'd0);
        check("t1_samples", {16'd0, dut_if.samples_done}, 32'd3);
        check("t1_nstarts", n_start - b, 32'd3);
        check("t1_regs4_0", log4[b], 32'h0100_0010);
        check("t1_regs4_1", log4[b+1], 32'h0104_0010);
        check("t1_regs4_2", log4[b+2], 32'h0108_0010);
        for (int i = 0; i < 3; i++) check("t1_regs3", log3[b+i], 32'h0002_0004);
        check("t1_gap1", {31'd0, gap_log[b+1] >= 3}, 32'd1);
        check("t1_gap2", {31'd0, gap_log[b+2] >= 3}, 32'd1);
        tick(); tick();
        check("t1_one_done", n_done - nd, 32'd1);
        check("t1_ready_back", {31'd0, dut_if.cmd_ready}, 32'd1);

        // Zero-sample minibatch
        b = n_start;
        send_cmd("t2", 16'd0, 16'd4, 16'h0010, 16'h0100, 16'd4, 2'b00);
        check("t2_done_not_yet", {31'd0, dut_if.done}, 32'd0);
        tick();
        check("t2_done", {31'd0, dut_if.done}, 32'd1);
        check("t2_samples", {16'd0, dut_if.samples_done}, 32'd0);
        tick();
        check("t2_done_pulse", {31'd0, dut_if.done}, 32'd0);
        check("t2_no_start", n_start - b, 32'd0);

        // Credit stall: result FIFO full for 50 cycles after sample 0
        tick();
        b = n_start;
        send_cmd("t3", 16'd2, 16'd1, 16'h0000, 16'h0000, 16'd1, 2'b00);
        wait_starts("t3a", b, 1, 20);
        dut_if.out_fifo_count = 10'd512;
        for (int k = 0; k < 100 && dut_if.samples_done !== 16'd1; k++) tick();
        check("t3_first_done", {16'd0, dut_if.samples_done}, 32'd1);
        for (int k = 0; k < 50; k++) tick();
        check("t3_held", n_start - b, 32'd1);
        dut_if.out_fifo_count = 10'd511;
        check("t3_no_start_yet", {31'd0, dut_if.dot_start}, 32'd0);
        tick();
        check("t3_start_after_credit", {31'd0, dut_if.dot_start}, 32'd1);
        dut_if.out_fifo_count = 10'd0;
        wait_done("t3", 200);
        check("t3_samples", {16'd0, dut_if.samples_done}, 32'd2);

        // Abort during WAIT of sample 2 of 5
        tick(); tick();
        b = n_start;
        send_cmd("t4", 16'd5, 16'd1, 16'h0020, 16'h0000, 16'd1, 2'b00);
        wait_starts("t4a", b, 2, 200);
        for (int k = 0; k < 5; k++) tick();
        dut_if.cmd_abort = 1'b1;
        tick();
        dut_if.cmd_abort = 1'b0;
        wait_done("t4", 200);
        check("t4_samples", {16'd0, dut_if.samples_done}, 32'd2);
        for (int k = 0; k < 30; k++) tick();
        check("t4_no_more_starts", n_start - b, 32'd2);
        b = n_start;
        send_cmd("t4b", 16'd1, 16'd2, 16'h0020, 16'h0040, 16'd1, 2'b01);
        wait_done("t4b", 200);
        check("t4b_samples", {16'd0, dut_if.samples_done}, 32'd1);
        check("t4b_regs4", log4[b], 32'h0040_0020);
        check("t4b_regs3", log3[b], 32'h0001_0002);

        // Labels offset wraparound
        tick(); tick();
        b = n_start;
        send_cmd("t5", 16'd2, 16'd8, 16'h0003, 16'hFFFE, 16'd4, 2'b01);
        wait_done("t5", 200);
        check("t5_regs4_0", log4[b], 32'hFFFE_0003);
        check("t5_regs4_1", log4[b+1], 32'h0002_0003);

        // Reset during WAIT; the late dot_done must be ignored
        tick(); tick();
        b = n_start;
        send_cmd("t6", 16'd3, 16'd1, 16'h0000, 16'h0000, 16'd1, 2'b00);
        wait_starts("t6a", b, 1, 20);
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        check("t6_cmd_ready", {31'd0, dut_if.cmd_ready}, 32'd0);
        check("t6_busy", {31'd0, dut_if.busy}, 32'd0);
        check("t6_regs3", dut_if.dot_regs3, 32'd0);
        check("t6_regs4", dut_if.dot_regs4, 32'd0);
        check("t6_samples", {16'd0, dut_if.samples_done}, 32'd0);
        check("t6_done", {31'd0, dut_if.done}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        check("t6_late_done_ignored", {16'd0, dut_if.samples_done}, 32'd0);
        check("t6_still_idle", {31'd0, dut_if.busy}, 32'd0);
        check("t6_no_restart", n_start - b, 32'd1);
        check("t6_ready", {31'd0, dut_if.cmd_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
